// File: rtl/edge_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : edge_count_sequencer
//  Purpose  : Measurement controller for the falling-edge counter datapath.
//             Opens a gate window of a programmed length, latches the count
//             and a wrap flag, and hands the result to a consumer through a
//             valid/ack handshake. Supports single-shot and continuous mode.
//  Revision : 1.0  initial release
// ============================================================================
module edge_count_sequencer #(
    parameter int WIDTH = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic [WIN_W-1:0] win_len,
    output logic             cnt_nul,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_ovf,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             overrun
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIN_W-1:0] c_win_one  = {{(WIN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_LATCH  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Captured measurement configuration
    logic [WIN_W-1:0]   r_win_len;
    logic               r_cont;

    // Window timer
    logic [WIN_W-1:0]   r_timer;
    logic [WIN_W-1:0]   w_timer_load;

    // Wrap detection
    logic [WIDTH-1:0]   r_prev;
    logic               r_wrap;
    logic               w_wrap_now;

    // Qualified events
    logic               w_start_ok;
    logic               w_abort;
    logic               w_capture;
    logic               w_enter_window;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    // A zero-length window is a no-op request; abort only matters while active.
    assign w_start_ok     = (r_state == ST_IDLE) && start && (win_len != '0);
    assign w_abort        = (r_state != ST_IDLE) && abort;
    assign w_capture      = (r_state == ST_LATCH) && !abort;
    assign w_enter_window = (w_state_nxt == ST_WINDOW) && (r_state != ST_WINDOW);
    // Restarting from IDLE uses the live win_len; continuous re-arm uses the copy.
    assign w_timer_load   = (r_state == ST_IDLE) ? win_len : r_win_len;

    // A wrap that lands on the final window edge is only visible during LATCH,
    // so the capture path also looks at the live comparison.
    assign w_wrap_now     = (r_prev == c_all_ones) && (cnt_value == '0);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; cnt_nul depends on state only.
    always_comb begin
        w_state_nxt = r_state;
        cnt_nul     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_WINDOW;
                end
            end
            ST_WINDOW: begin
                cnt_nul = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == c_win_one) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cont) begin
                    w_state_nxt = ST_WINDOW;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Configuration and timer
    // ------------------------------------------------------------------------
    // Capture window length and mode on an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_len <= '0;
            r_cont    <= 1'b0;
        end else if (w_start_ok) begin
            r_win_len <= win_len;
            r_cont    <= continuous;
        end
    end

    // Window timer: loaded on window entry, counts down to 1 during WINDOW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_enter_window) begin
            r_timer <= w_timer_load;
        end else if ((r_state == ST_WINDOW) && !abort) begin
            r_timer <= r_timer - c_win_one;
        end else if (w_state_nxt == ST_IDLE) begin
            r_timer <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Wrap detection
    // ------------------------------------------------------------------------
    // Track the previous count while active; the history is cleared on every
    // window entry so a full count from the last window cannot fake a wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= '0;
            r_wrap <= 1'b0;
        end else if (w_enter_window) begin
            r_prev <= '0;
            r_wrap <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            r_prev <= cnt_value;
            if (w_wrap_now) begin
                r_wrap <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result handshake
    // ------------------------------------------------------------------------
    // Capture on LATCH (unless aborted); an ack on the capture edge is absorbed
    // by the new data, otherwise ack drops valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result       <= '0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
        end else if (w_capture) begin
            result       <= cnt_value;
            result_ovf   <= r_wrap | w_wrap_now;
            result_valid <= 1'b1;
        end else if (result_ack) begin
            result_valid <= 1'b0;
        end
    end

    // Sticky overrun: set when an unacknowledged result is overwritten,
    // cleared by an accepted start or by abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (w_start_ok || w_abort) begin
            overrun <= 1'b0;
        end else if (w_capture && result_valid && !result_ack) begin
            overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_count_sequencer
//  Purpose  : Self-checking bench for edge_count_sequencer with a behavioural
//             edge counter, a per-window counting model and a result
//             scoreboard drained by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_edge_count_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] win_len = '0;
    logic        cnt_nul;
    logic [7:0]  cnt_value = '0;
    logic        busy;
    logic [7:0]  result;
    logic        result_ovf;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        overrun;

    bit          inc = 1'b0;     // one counted falling edge in the current cycle
    bit          mon_en = 1'b1;
    bit          auto_ack = 1'b1;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [7:0] r;
        logic       o;
    } exp_t;
    exp_t sb_q[$];

    edge_count_sequencer #(.WIDTH(8), .WIN_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .continuous   (continuous),
        .win_len      (win_len),
        .cnt_nul      (cnt_nul),
        .cnt_value    (cnt_value),
        .busy         (busy),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in for the edge counter: synchronous active-low clear has priority.
    always @(posedge clk) begin
        if (!cnt_nul) cnt_value <= '0;
        else if (inc) cnt_value <= cnt_value + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising result_valid is matched against the scoreboard.
    initial begin
        bit prev_v;
        bit acked;
        exp_t e;
        prev_v = 1'b0;
        acked  = 1'b0;
        forever begin
            @(negedge clk);
            if (acked) begin
                result_ack = 1'b0;
                acked = 1'b0;
            end
            if (result_valid === 1'b1 && !prev_v) begin
                if (mon_en) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got result 0x%0h ovf %0b, expected no result", result, result_ovf);
                    end else begin
                        e = sb_q.pop_front();
                        if (result !== e.r || result_ovf !== e.o) begin
                            errors++;
                            $display("FAIL sb_result: got 0x%0h ovf %0b, expected 0x%0h ovf %0b", result, result_ovf, e.r, e.o);
                        end
                    end
                end
                if (auto_ack) begin
                    result_ack = 1'b1;
                    acked = 1'b1;
                end
            end
            prev_v = (result_valid === 1'b1);
        end
    end

    // Single-shot measurement. Window edges: mode 0 none, 1 first n_edges, 2 random.
    // Edges outside the window are always driven to show they are not counted.
    task automatic measure(input int win, input int mode, input int n_edges, output logic [7:0] exp_r);
        int cnt;
        bit b;
        exp_t e;
        cnt = 0;
        start = 1'b1; win_len = 16'(win); continuous = 1'b0; inc = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= win; i++) begin
            if (i == 1) chk("window_entry", {30'd0, busy, cnt_nul}, 32'd3);
            case (mode)
                0:       b = 1'b0;
                1:       b = (i <= n_edges);
                default: b = 1'($urandom_range(0, 1));
            endcase
            inc = b;
            cnt += int'(b);
            tick();
        end
        inc = 1'b1;
        chk("latch_cycle", {29'd0, busy, cnt_nul, result_valid}, 32'd4);
        e.r = cnt[7:0];
        e.o = (cnt >= 256);
        sb_q.push_back(e);
        tick();
        inc = 1'b0;
        chk("after_latch", {29'd0, busy, cnt_nul, result_valid}, 32'd1);
        exp_r = cnt[7:0];
    endtask

    // Continuous run of n captures, then abort in the next window.
    task automatic cont_run(input int win, input int n, input bit ack_cap, input bit use_sb, input bit valid_before);
        int cnt;
        bit ev, eo;
        exp_t e;
        ev = valid_before;
        eo = 1'b0;
        e.r = '0;
        e.o = 1'b0;
        start = 1'b1; win_len = 16'(win); continuous = 1'b1; inc = 1'b1;
        tick();
        start = 1'b0; continuous = 1'b0;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            for (int i = 1; i <= win; i++) begin
                inc = 1'($urandom_range(0, 1));
                cnt += int'(inc);
                tick();
            end
            inc = 1'b1;
            if (ack_cap) result_ack = 1'b1;
            chk("cont_latch", {30'd0, busy, cnt_nul}, 32'd2);
            e.r = cnt[7:0];
            e.o = (cnt >= 256);
            if (use_sb) sb_q.push_back(e);
            if (ev && !ack_cap) eo = 1'b1;
            ev = 1'b1;
            tick();
            result_ack = 1'b0;
            if (!use_sb) begin
                chk("cont_result", {22'd0, result_valid, overrun, result_ovf, result},
                    {22'd0, ev, eo, e.o, e.r});
            end
        end
        abort = 1'b1; inc = 1'b1;
        tick();
        abort = 1'b0; inc = 1'b0;
        chk("cont_abort", {29'd0, busy, cnt_nul, overrun}, 32'd0);
        if (!use_sb) chk("cont_abort_keep", {23'd0, result_valid, result}, {23'd0, ev, e.r});
    endtask

    task automatic ack_now();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("manual_ack", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] prior;
        int w;

        // Reset values, asynchronous, before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("reset_flags", {27'd0, busy, cnt_nul, result_valid, result_ovf, overrun}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic single shot: 3 edges in a 10-cycle window.
        measure(10, 1, 3, r);
        chk("basic_count", {24'd0, r}, 32'd3);

        // Gating: edges only outside a 5-cycle window.
        inc = 1'b1;
        repeat (3) tick();
        measure(5, 0, 0, r);

        // Zero-length window is ignored.
        start = 1'b1; win_len = 16'd0; inc = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("zero_win", {29'd0, busy, cnt_nul, result_valid}, 32'd0);
        inc = 1'b0;

        // Wrap: 260 edges in a 1000-cycle window, then a clean 2-edge window.
        measure(1000, 1, 260, r);
        measure(7, 1, 2, r);

        // Randomized mix of single-shot and continuous measurements.
        for (int it = 0; it < 10; it++) begin
            w = $urandom_range(1, 40);
            if ($urandom_range(0, 2) == 0) cont_run(w, $urandom_range(1, 3), 1'b0, 1'b1, 1'b0);
            else measure(w, 2, 0, r);
        end
        measure(600, 2, 0, r);

        // Continuous without ack: overrun after the second capture.
        repeat (3) tick();
        mon_en = 1'b0; auto_ack = 1'b0;
        cont_run(4, 3, 1'b0, 1'b0, 1'b0);
        // Continuous with ack on each capture edge: valid held, no overrun.
        cont_run(4, 3, 1'b1, 1'b0, 1'b1);
        ack_now();
        mon_en = 1'b1;

        // Abort in cycle 3 of an 8-cycle window keeps the prior result.
        measure(6, 1, 5, prior);
        start = 1'b1; win_len = 16'd8; inc = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {23'd0, busy, cnt_nul, result_valid, result}, {23'd0, 1'b0, 1'b0, 1'b1, prior});
        repeat (8) tick();
        chk("abort_no_capture", {24'd0, result}, {24'd0, prior});
        inc = 1'b0;
        ack_now();
        auto_ack = 1'b1;

        // Reset in the middle of a window, checked before the next clock edge.
        start = 1'b1; win_len = 16'd20; inc = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        chk("midreset_flags", {27'd0, busy, cnt_nul, result_valid, result_ovf, overrun}, 32'd0);
        chk("midreset_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        inc = 1'b0;
        tick();
        measure(15, 2, 0, r);

        repeat (5) tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
